// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, decoder redirect inputs
// and the decoded-field outputs presented to the main decoder.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            pc_src;
  logic            jalr;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] jalr_target;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_err;
  logic [1:0]      err_code;

  modport master (
    input  imem_ack, imem_rdata, stall, pc_src, jalr, target_pc, jalr_target,
    output imem_req, imem_addr, instr_valid, instr, opcode, funct3, rd, rs1, rs2,
           pc, pc_plus4, fetch_err, err_code
  );

  modport slave (
    output imem_ack, imem_rdata, stall, pc_src, jalr, target_pc, jalr_target,
    input  imem_req, imem_addr, instr_valid, instr, opcode, funct3, rd, rs1, rs2,
           pc, pc_plus4, fetch_err, err_code
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle RISC-V fetch stage: PC, imem req/ack with timeout, instruction
// register feeding the decoder, and next-PC selection with misalignment trap.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FETCH, ISSUE, ERR} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_req;
  logic            r_vld;
  logic            r_err;
  logic [1:0]      r_code;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + XLEN'(4);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.jalr)        w_next_pc = bus.jalr_target & ~XLEN'(1);
    else if (bus.pc_src) w_next_pc = bus.target_pc;
  end

  // r_req stays low for the first cycle after reset so the request line is
  // never raised while reset is asserted and starts one cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_req   <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= ISSUE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_code  <= 2'b01;
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ISSUE: begin
          if (!bus.stall) begin
            r_vld <= 1'b0;
            if (w_next_pc[1:0] != 2'b00) begin
              r_err   <= 1'b1;
              r_code  <= 2'b10;
              r_state <= ERR;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= FETCH;
            end
          end
        end
        default: begin
          r_req <= 1'b0;
          r_vld <= 1'b0;
          r_err <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_vld;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[6:0];
  assign bus.funct3      = r_instr[14:12];
  assign bus.rd          = r_instr[11:7];
  assign bus.rs1         = r_instr[19:15];
  assign bus.rs2         = r_instr[24:20];
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.fetch_err   = r_err;
  assign bus.err_code    = r_code;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: the stimulus thread queues expected fetch addresses and
// decoded instructions; a negedge monitor pops and compares on req/valid rises.
module tb_instr_fetch_unit;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [31:0] q_addr[$];
  exp_t        q_item[$];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus ();
  instr_fetch_unit_if #(.XLEN(32)) bus2 ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) dut2 (
    .clk(clk), .reset(rst), .bus(bus2)
  );

  // second unit: always-ready memory, straight-line code, checks PC wrap
  assign bus2.imem_ack    = bus2.imem_req;
  assign bus2.imem_rdata  = 32'h0000_0013;
  assign bus2.stall       = 1'b0;
  assign bus2.pc_src      = 1'b0;
  assign bus2.jalr        = 1'b0;
  assign bus2.target_pc   = '0;
  assign bus2.jalr_target = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor
  logic prev_req = 1'b0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.imem_req && !prev_req) begin
      if (q_addr.size() == 0) chk("unexpected_req", bus.imem_addr, 32'hxxxx_xxxx);
      else chk("fetch_addr", bus.imem_addr, q_addr.pop_front());
    end
    if (!rst && bus.instr_valid && !prev_vld) begin
      if (q_item.size() == 0) begin
        chk("unexpected_valid", bus.instr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q_item.pop_front();
        chk("instr",    bus.instr,           e.instr);
        chk("pc",       bus.pc,              e.pc);
        chk("pc_plus4", bus.pc_plus4,        e.pc4);
        chk("opcode",   32'(bus.opcode),     32'(e.op));
        chk("funct3",   32'(bus.funct3),     32'(e.f3));
        chk("rd",       32'(bus.rd),         32'(e.rd));
        chk("rs1",      32'(bus.rs1),        32'(e.rs1));
        chk("rs2",      32'(bus.rs2),        32'(e.rs2));
      end
    end
    prev_req = rst ? 1'b0 : bus.imem_req;
    prev_vld = rst ? 1'b0 : bus.instr_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    bus.stall = 1'b0; bus.pc_src = 1'b0; bus.jalr = 1'b0;
    bus.target_pc = '0; bus.jalr_target = '0;
  endtask

  // serve one fetch: wait for req, ack after dly cycles, apply decode outcome
  task automatic serve(input exp_t e, input int dly, input int stl,
                       input logic ps, input logic [31:0] tg,
                       input logic jl, input logic [31:0] jt);
    int n;
    q_addr.push_back(e.pc);
    q_item.push_back(e);
    n = 0;
    while (!bus.imem_req && n < 50) begin tick(); n++; end
    if (!bus.imem_req) begin
      chk("req_wait_timeout", 32'(bus.imem_req), 32'd1);
      return;
    end
    repeat (dly) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = e.instr;
    bus.stall = (stl > 0); bus.pc_src = ps; bus.target_pc = tg;
    bus.jalr = jl; bus.jalr_target = jt;
    tick();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < stl; i++) begin
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_noreq", 32'(bus.imem_req), 32'd0);
      chk("stall_instr", bus.instr, e.instr);
      chk("stall_pc", bus.pc, e.pc);
      tick();
    end
    bus.stall = 1'b0;
    chk("issue_valid", 32'(bus.instr_valid), 32'd1);
    tick();
    clr_ctrl();
    chk("valid_drop", 32'(bus.instr_valid), 32'd0);
  endtask

  exp_t vA = '{32'h0050_0093, 32'h0000_0000, 32'h0000_0004, 7'h13, 3'd0, 5'd1, 5'd0, 5'd5};
  exp_t vB = '{32'h0040_A103, 32'h0000_0004, 32'h0000_0008, 7'h03, 3'd2, 5'd2, 5'd1, 5'd4};
  exp_t vC = '{32'h00A3_0333, 32'h0000_0008, 32'h0000_000C, 7'h33, 3'd0, 5'd6, 5'd6, 5'd10};
  exp_t vD = '{32'h0020_8463, 32'h0000_000C, 32'h0000_0010, 7'h63, 3'd0, 5'd8, 5'd1, 5'd2};
  exp_t vE = '{32'hFFC4_A303, 32'h0000_0100, 32'h0000_0104, 7'h03, 3'd2, 5'd6, 5'd9, 5'd28};
  exp_t vF = '{32'h0050_0093, 32'h0000_0204, 32'h0000_0208, 7'h13, 3'd0, 5'd1, 5'd0, 5'd5};
  exp_t vG = '{32'h0040_A103, 32'h0000_0000, 32'h0000_0004, 7'h03, 3'd2, 5'd2, 5'd1, 5'd4};

  // wrap check on the second unit, right after the first reset release
  initial begin
    @(negedge rst);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_first_req", 32'(bus2.imem_req), 32'd1);
    chk("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc_plus4", bus2.pc_plus4, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_second_req", 32'(bus2.imem_req), 32'd1);
    chk("wrap_second_addr", bus2.imem_addr, 32'h0000_0000);
  end

  initial begin
    int n;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    clr_ctrl();
    repeat (2) tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_err", {29'd0, bus.fetch_err, bus.err_code}, 32'd0);
    rst = 1'b0;

    serve(vA, 1, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    serve(vB, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    serve(vC, 0, 3, 1'b0, 32'h0, 1'b0, 32'h0);
    serve(vD, 0, 0, 1'b1, 32'h100, 1'b0, 32'h0);
    serve(vE, 0, 0, 1'b1, 32'h300, 1'b1, 32'h205);
    serve(vF, 0, 0, 1'b1, 32'h102, 1'b0, 32'h0);
    repeat (3) begin
      chk("mis_err", 32'(bus.fetch_err), 32'd1);
      chk("mis_code", 32'(bus.err_code), 32'd2);
      chk("mis_noreq", 32'(bus.imem_req), 32'd0);
      tick();
    end
    chk("mis_pc_held", bus.pc, 32'h0000_0204);

    // timeout: no ack at all
    rst = 1'b1; tick();
    chk("rst2_err", 32'(bus.fetch_err), 32'd0);
    q_addr.push_back(32'h0);
    rst = 1'b0;
    n = 0;
    while (!bus.imem_req && n < 10) begin tick(); n++; end
    n = 0;
    while (bus.imem_req && n < 20) begin tick(); n++; end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_err", 32'(bus.fetch_err), 32'd1);
    chk("timeout_code", 32'(bus.err_code), 32'd1);

    // ack on the final allowed cycle wins over timeout
    rst = 1'b1; tick();
    rst = 1'b0;
    serve(vG, 3, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("late_ack_noerr", 32'(bus.fetch_err), 32'd0);
    q_addr.push_back(32'h4);
    tick();

    // reset mid-fetch
    chk("midfetch_req", 32'(bus.imem_req), 32'd1);
    rst = 1'b1; #1;
    chk("midfetch_drop", 32'(bus.imem_req), 32'd0);
    tick();
    q_addr.push_back(32'h0);
    rst = 1'b0;
    chk("post_rst_noreq", 32'(bus.imem_req), 32'd0);
    tick();
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    tick();
    chk("addr_q_empty", 32'(q_addr.size()), 32'd0);
    chk("item_q_empty", 32'(q_item.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
endmodule
